apb_gpio_filt: RTL and testbench

//  APB3 slave GPIO block with per-pin glitch filtering, edge interrupts and W1C status.

---
 rtl/apb_gpio_filt_pkg.sv | 34 +++
 rtl/apb_gpio_filt_if.sv | 29 ++
 rtl/apb_gpio_filt_ch.sv | 69 ++++++
 rtl/apb_gpio_filt.sv | 145 ++++++++++++++
 tb/tb_apb_gpio_filt.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_gpio_filt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_gpio_filt_pkg
//  Purpose  : Shared declarations for the filtered APB GPIO block: register
//             word indices, highest mapped byte offset, decode error helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package apb_gpio_filt_pkg;

  // Highest mapped byte offset (CLR register)
  localparam logic [7:0] ADDR_MAX = 8'h24;

  // Register word index = PADDR[7:2]
  typedef enum logic [5:0] {
    REG_OE   = 6'd0,  // 0x00 RW
    REG_OUT  = 6'd1,  // 0x04 RW
    REG_IN   = 6'd2,  // 0x08 RO debounced pin value
    REG_IEN  = 6'd3,  // 0x0C RW
    REG_RISE = 6'd4,  // 0x10 RW rising-edge enable
    REG_FALL = 6'd5,  // 0x14 RW falling-edge enable
    REG_STAT = 6'd6,  // 0x18 W1C
    REG_DBC  = 6'd7,  // 0x1C RW debounce count
    REG_SET  = 6'd8,  // 0x20 WO OUT |= wdata
    REG_CLR  = 6'd9   // 0x24 WO OUT &= ~wdata
  } reg_idx_e;

  // Byte address beyond the map; low two address bits play no part
  function automatic logic addr_err(input logic [7:0] paddr);
    return paddr[7:2] > ADDR_MAX[7:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_gpio_filt_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_gpio_filt_if
//  Purpose  : APB3 bus bundle for the GPIO block.
//  Signals  : PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[31:0]  (master->slave)
//             PRDATA[31:0], PREADY, PSLVERR                     (slave->master)
//  Revision : 1.0  initial release
// ============================================================================
interface apb_gpio_filt_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_gpio_filt_ch.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_filt_ch
//  Purpose  : One GPIO input channel: 2-flop synchroniser, debounce counter,
//             debounced (stable) value and single-cycle edge pulses.
//  Ports    : clk, rst_n      clock, async active-low reset
//             pin_i           asynchronous pin input
//             dbc_i[DEB_W]    debounce count (0 behaves as 1)
//             stable_o        debounced value
//             rise_o/fall_o   one-cycle pulse in the cycle after stable changes
//  Revision : 1.0  initial release
// ============================================================================
module gpio_filt_ch #(
  parameter int DEB_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             pin_i,
  input  wire logic [DEB_W-1:0] dbc_i,
  output logic                  stable_o,
  output logic                  rise_o,
  output logic                  fall_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] thr;

  // A new level must be seen for max(dbc,1) consecutive cycles; the counter
  // reaching max(dbc,1)-1 means this cycle is the last one required.
  assign thr = (dbc_i == '0) ? '0 : dbc_i - DEB_W'(1);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // >= rather than == so a threshold lowered mid-count still fires
      if (cnt_q >= thr) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~prev_q;
  assign fall_o   = ~stable_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_filt.sv
`default_nettype none
// ============================================================================
//  Module   : apb_gpio_filt
//  Purpose  : APB3 GPIO slave with per-pin debounce, rise/fall edge capture
//             into a W1C status register and masked interrupts.
//  Ports    : PCLK, PRESETN        clock, async active-low reset
//             apb (slave modport)  APB3 bus, zero wait state
//             GPIO_IN[IO_NUM]      asynchronous pin inputs
//             GPIO_OUT[IO_NUM]     output values
//             GPIO_OE[IO_NUM]      output enables, 1 = drive
//             INT[IO_NUM]          STAT & IEN
//             INT_OR               OR of INT
//  Revision : 1.0  initial release
// ============================================================================
module apb_gpio_filt
  import apb_gpio_filt_pkg::*;
#(
  parameter int               IO_NUM  = 32,
  parameter int               DEB_W   = 8,
  parameter logic [IO_NUM-1:0] OUT_RST = '0,
  parameter logic [IO_NUM-1:0] OE_RST  = '0
) (
  input  wire logic              PCLK,
  input  wire logic              PRESETN,
  apb_gpio_filt_if.slave         apb,
  input  wire logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0]      GPIO_OUT,
  output logic [IO_NUM-1:0]      GPIO_OE,
  output logic [IO_NUM-1:0]      INT,
  output logic                   INT_OR
);

  logic [IO_NUM-1:0] oe_q,   oe_d;
  logic [IO_NUM-1:0] out_q,  out_d;
  logic [IO_NUM-1:0] ien_q,  ien_d;
  logic [IO_NUM-1:0] rise_q, rise_d;
  logic [IO_NUM-1:0] fall_q, fall_d;
  logic [IO_NUM-1:0] stat_q, stat_d;
  logic [DEB_W-1:0]  dbc_q,  dbc_d;

  logic [IO_NUM-1:0] stable_w, rise_ev, fall_ev;
  logic [IO_NUM-1:0] wdata, stat_clr;
  logic [31:0]       rdata;
  logic              err, wr_en;
  reg_idx_e          idx;
  logic              unused_ok;

  assign idx       = reg_idx_e'(apb.PADDR[7:2]);
  assign err       = addr_err(apb.PADDR);
  assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE & ~err;
  assign wdata     = apb.PWDATA[IO_NUM-1:0];
  assign unused_ok = ^apb.PADDR[1:0];

  // ---------------------------------------------------------------- channels
  genvar gi;
  generate
    for (gi = 0; gi < IO_NUM; gi++) begin : g_ch
      gpio_filt_ch #(.DEB_W(DEB_W)) u_ch (
        .clk      (PCLK),
        .rst_n    (PRESETN),
        .pin_i    (GPIO_IN[gi]),
        .dbc_i    (dbc_q),
        .stable_o (stable_w[gi]),
        .rise_o   (rise_ev[gi]),
        .fall_o   (fall_ev[gi])
      );
    end
  endgenerate

  // ------------------------------------------------------ register write path
  always_comb begin
    oe_d     = oe_q;
    out_d    = out_q;
    ien_d    = ien_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    dbc_d    = dbc_q;
    stat_clr = '0;
    if (wr_en) begin
      case (idx)
        REG_OE:   oe_d     = wdata;
        REG_OUT:  out_d    = wdata;
        REG_IEN:  ien_d    = wdata;
        REG_RISE: rise_d   = wdata;
        REG_FALL: fall_d   = wdata;
        REG_STAT: stat_clr = wdata;
        REG_DBC:  dbc_d    = apb.PWDATA[DEB_W-1:0];
        REG_SET:  out_d    = out_q | wdata;
        REG_CLR:  out_d    = out_q & ~wdata;
        default:  ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident edge survives
    stat_d = (stat_q & ~stat_clr) | (rise_ev & rise_q) | (fall_ev & fall_q);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      oe_q   <= OE_RST;
      out_q  <= OUT_RST;
      ien_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      dbc_q  <= '0;
    end else begin
      oe_q   <= oe_d;
      out_q  <= out_d;
      ien_q  <= ien_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stat_q <= stat_d;
      dbc_q  <= dbc_d;
    end
  end

  // ------------------------------------------------------- register read path
  always_comb begin
    rdata = '0;
    if (apb.PSEL && !apb.PWRITE && !err) begin
      case (idx)
        REG_OE:   rdata[IO_NUM-1:0] = oe_q;
        REG_OUT:  rdata[IO_NUM-1:0] = out_q;
        REG_IN:   rdata[IO_NUM-1:0] = stable_w;
        REG_IEN:  rdata[IO_NUM-1:0] = ien_q;
        REG_RISE: rdata[IO_NUM-1:0] = rise_q;
        REG_FALL: rdata[IO_NUM-1:0] = fall_q;
        REG_STAT: rdata[IO_NUM-1:0] = stat_q;
        REG_DBC:  rdata[DEB_W-1:0]  = dbc_q;
        default:  ;  // SET/CLR are write-only
      endcase
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & err;

  assign GPIO_OUT = out_q;
  assign GPIO_OE  = oe_q;
  assign INT      = stat_q & ien_q;
  assign INT_OR   = |(stat_q & ien_q);

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_filt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_gpio_filt
//  Purpose  : Self-checking bench for apb_gpio_filt. APB transfers push their
//             expected response into a scoreboard queue; a monitor pops and
//             compares on every access phase. Expected values come from a
//             behavioural model built on a history of sampled pin values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_gpio_filt;

  localparam int          IO       = 12;
  localparam logic [IO-1:0] OUT_RST_V = 12'h0A5;
  localparam logic [IO-1:0] OE_RST_V  = 12'h00F;
  localparam int          HD       = 64;

  logic          PCLK    = 1'b0;
  logic          PRESETN = 1'b1;
  logic [IO-1:0] gpio_in = '0;
  logic [IO-1:0] gpio_out, gpio_oe, int_v;
  logic          int_or;

  apb_gpio_filt_if bus();

  apb_gpio_filt #(
    .IO_NUM (IO),
    .DEB_W  (8),
    .OUT_RST(OUT_RST_V),
    .OE_RST (OE_RST_V)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .apb     (bus.slave),
    .GPIO_IN (gpio_in),
    .GPIO_OUT(gpio_out),
    .GPIO_OE (gpio_oe),
    .INT     (int_v),
    .INT_OR  (int_or)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [IO-1:0] m_oe, m_out, m_ien, m_rise, m_fall, m_stat, m_stable;
  logic [IO-1:0] pend_r, pend_f;
  logic [7:0]    m_dbc;
  logic [IO-1:0] hist [HD];   // hist[0] = pin value sampled at the previous edge

  always @(posedge PCLK or negedge PRESETN) begin : model
    logic [IO-1:0] set_v, flip, clr, wd;
    int            n;
    bit            all_diff;
    if (!PRESETN) begin
      m_oe = OE_RST_V; m_out = OUT_RST_V; m_ien = '0; m_rise = '0; m_fall = '0;
      m_stat = '0; m_stable = '0; pend_r = '0; pend_f = '0; m_dbc = '0;
      for (int d = 0; d < HD; d++) hist[d] = '0;
    end else begin
      set_v = (pend_r & m_rise) | (pend_f & m_fall);
      // a pin flips when the last max(DBC,1) synchronised samples all differ
      n = (m_dbc == 0) ? 1 : int'(m_dbc);
      if (n > HD - 1) n = HD - 1;
      flip = '0;
      for (int i = 0; i < IO; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= n; j++)
          if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
      pend_r   = flip & ~m_stable;
      pend_f   = flip & m_stable;
      m_stable = m_stable ^ flip;
      for (int d = HD - 1; d > 0; d--) hist[d] = hist[d-1];
      hist[0] = gpio_in;
      clr = '0;
      wd  = bus.PWDATA[IO-1:0];
      if (bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PADDR[7:2] <= 6'd9) begin
        case (bus.PADDR[7:2])
          6'd0: m_oe   = wd;
          6'd1: m_out  = wd;
          6'd3: m_ien  = wd;
          6'd4: m_rise = wd;
          6'd5: m_fall = wd;
          6'd6: clr    = wd;
          6'd7: m_dbc  = bus.PWDATA[7:0];
          6'd8: m_out  = m_out | wd;
          6'd9: m_out  = m_out & ~wd;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | set_v;
    end
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    case (a[7:2])
      6'd0: r[IO-1:0] = m_oe;
      6'd1: r[IO-1:0] = m_out;
      6'd2: r[IO-1:0] = m_stable;
      6'd3: r[IO-1:0] = m_ien;
      6'd4: r[IO-1:0] = m_rise;
      6'd5: r[IO-1:0] = m_fall;
      6'd6: r[IO-1:0] = m_stat;
      6'd7: r[7:0]    = m_dbc;
      default: ;
    endcase
    return r;
  endfunction

  // ------------------------------------------------------------- scoreboard
  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sbq[$];

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic use_c, input logic [31:0] cexp, input string nm);
    exp_t e;
    bus.PSEL = 1'b1; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd; bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    e.err  = (addr[7:2] > 6'd9);
    e.data = wr ? 32'h0 : (use_c ? cexp : model_read(addr));
    e.name = nm;
    sbq.push_back(e);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd_c(input logic [7:0] a, input logic [31:0] exp, input string nm);
    xfer(1'b0, a, 32'h0, 1'b1, exp, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge PCLK); #1; end
  endtask

  always @(negedge PCLK) begin : monitor
    exp_t e;
    ck("gpio_out", 32'(gpio_out), 32'(m_out));
    ck("gpio_oe",  32'(gpio_oe),  32'(m_oe));
    ck("int",      32'(int_v),    32'(m_stat & m_ien));
    ck("int_or",   32'(int_or),   32'(|(m_stat & m_ien)));
    if (bus.PSEL && bus.PENABLE) begin
      if (sbq.size() == 0) begin
        ck("sb_unexpected", 32'h1, 32'h0);
      end else begin
        e = sbq.pop_front();
        ck(e.name, bus.PRDATA, e.data);
        ck({e.name, "_slverr"}, 32'(bus.PSLVERR), 32'(e.err));
        ck("pready", 32'(bus.PREADY), 32'h1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------- stimulus
  initial begin : stim
    int          c;
    bit          found;
    logic [5:0]  ai;
    logic [7:0]  a;
    logic [31:0] d;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;

    // 1: reset values
    #1 PRESETN = 1'b0;
    #2;
    ck("rst_out",    32'(gpio_out), 32'(OUT_RST_V));
    ck("rst_oe",     32'(gpio_oe),  32'(OE_RST_V));
    ck("rst_int_or", 32'(int_or),   32'h0);
    ck("rst_pready", 32'(bus.PREADY), 32'h1);
    ck("rst_prdata", bus.PRDATA,    32'h0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETN = 1'b1;
    idle(2);
    rd_c(8'h00, 32'h00F, "rd_oe_rst");
    rd_c(8'h04, 32'h0A5, "rd_out_rst");
    rd_c(8'h18, 32'h000, "rd_stat_rst");

    // 2: DBC=4 rising edge on pin 3, INT_OR seven edges after drive point
    wr(8'h1C, 32'd4);
    wr(8'h10, 32'h8);
    wr(8'h0C, 32'h8);
    gpio_in[3] = 1'b1;
    found = 1'b0; c = 0;
    while (!found && c < 20) begin
      @(posedge PCLK); #1; c++;
      if (int_or) found = 1'b1;
    end
    ck("int_latency", 32'(c), 32'd7);
    rd_c(8'h08, 32'h8, "rd_in_p3");
    rd_c(8'h18, 32'h8, "rd_stat_p3");

    // 3: short pulses against the debounce filter
    gpio_in = '0;
    idle(10);
    wr(8'h10, 32'hFFF);
    wr(8'h14, 32'hFFF);
    wr(8'h18, 32'hFFF);
    rd_c(8'h18, 32'h0, "rd_stat_clr");
    gpio_in[0] = 1'b1;
    idle(3);
    gpio_in[0] = 1'b0;
    idle(12);
    rd_c(8'h08, 32'h0, "rd_in_pulse3");
    rd_c(8'h18, 32'h0, "rd_stat_pulse3");
    wr(8'h1C, 32'd0);
    gpio_in[0] = 1'b1;
    idle(1);
    gpio_in[0] = 1'b0;
    idle(8);
    rd_c(8'h08, 32'h0, "rd_in_pulse1");
    rd_c(8'h18, 32'h1, "rd_stat_pulse1");

    // 4: W1C clear coinciding with a new edge
    wr(8'h18, 32'hFFF);
    wr(8'h10, 32'h9);
    wr(8'h14, 32'h1);
    gpio_in = 12'h009;
    idle(6);
    rd_c(8'h18, 32'h9, "rd_stat_9");
    gpio_in = 12'h008;
    @(posedge PCLK); @(posedge PCLK); #1;
    wr(8'h18, 32'h1);
    rd_c(8'h18, 32'h9, "rd_stat_setwins");
    wr(8'h18, 32'h8);
    rd_c(8'h18, 32'h1, "rd_stat_w1c");

    // 5: SET/CLR and decode error
    wr(8'h04, 32'hF0);
    wr(8'h20, 32'h0F);
    rd_c(8'h04, 32'hFF, "rd_out_set");
    wr(8'h24, 32'h81);
    rd_c(8'h04, 32'h7E, "rd_out_clr");
    xfer(1'b1, 8'h40, 32'hFFF, 1'b0, 32'h0, "wr_err");
    xfer(1'b0, 8'h40, 32'h0,   1'b1, 32'h0, "rd_err");
    rd_c(8'h04, 32'h7E, "rd_out_after_err");
    rd_c(8'h20, 32'h0, "rd_set_wo");

    // randomized traffic, checked against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, IO - 1);
        gpio_in[c] = ~gpio_in[c];
      end
      ai = 6'($urandom_range(0, 11));
      a  = {ai, 2'($urandom_range(0, 3))};
      d  = $urandom;
      if (ai == 6'd7) d = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) xfer(1'b0, a, 32'h0, 1'b0, 32'h0, "rnd_rd");
      else                           xfer(1'b1, a, d,     1'b0, 32'h0, "rnd_wr");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    // 6: asynchronous reset while a pin is mid-count
    wr(8'h1C, 32'd6);
    gpio_in = 12'h020;
    idle(4);
    #3 PRESETN = 1'b0;
    #1;
    ck("arst_out",    32'(gpio_out), 32'(OUT_RST_V));
    ck("arst_oe",     32'(gpio_oe),  32'(OE_RST_V));
    ck("arst_int",    32'(int_v),    32'h0);
    ck("arst_int_or", 32'(int_or),   32'h0);
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETN = 1'b1;
    wr(8'h10, 32'hFFF);
    idle(4);
    rd_c(8'h18, 32'h020, "rd_stat_post_rst");
    rd_c(8'h08, 32'h020, "rd_in_post_rst");

    idle(2);
    ck("sb_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
